// File: rtl/clksel_fsm.sv
// clksel_fsm: chooses between the high-speed (HS) and low-speed (LS) CPU clock
// sources for each decoded CPU cycle. It drives the HS-select request into the
// glitch-free clock switch and waits for the switch's synchronised feedback
// before it lets the CPU continue. The CPU is stalled while a switch is pending.
//
// Optional feature: define SWITCH_TIMEOUT_EN to build a per-switch timeout.
// When it is enabled, a switch that does not complete within TIMEOUT_CYCLES
// sets the sticky timeout_err flag and falls back towards LS. When it is not
// defined, timeout_err is tied to 0 and the switch states wait indefinitely.
//
// Handshake: there is no ready/valid pair. cyc_valid is a one-cycle strobe.
// The requester must hold its triggering cycle while stall=1. Any cyc_valid
// that arrives while stall=1 is ignored.

module clksel_fsm #(
  parameter int SYNC_STAGES    = 2,
  parameter int LS_HOLD_CYCLES = 8,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       hsclk_in,
  input  logic       rst,
  input  logic       cyc_valid,
  input  logic       fast_req,
  input  logic       force_ls,
  input  logic       hsclk_selected_in,
  input  logic       lsclk_selected_in,
  output logic       hsclk_sel,
  output logic       stall,
  output logic [1:0] state_o,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    LS_RUN = 2'd0,
    TO_HS  = 2'd1,
    HS_RUN = 2'd2,
    TO_LS  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(LS_HOLD_CYCLES);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   hold_nxt;
  logic               sel_nxt;
  logic               stall_nxt;
  logic               timed_out;

  logic [SYNC_STAGES-1:0] hs_sync;
  logic [SYNC_STAGES-1:0] ls_sync;
  logic                   hs_s;
  logic                   ls_s;

  // Synchronise the asynchronous switch feedback. The reset values match a
  // switch that sits on LS (HS not selected, LS selected).
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      hs_sync <= '0;
      ls_sync <= '1;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], hsclk_selected_in};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], lsclk_selected_in};
    end
  end

  assign hs_s = hs_sync[SYNC_STAGES-1];
  assign ls_s = ls_sync[SYNC_STAGES-1];

`ifdef SWITCH_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  assign timed_out = state[0] && (to_cnt == TO_LIMIT);

  // Count the cycles spent in a switch state. Restart on every entry into
  // TO_HS or TO_LS, including TO_HS -> TO_LS.
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state_nxt[0] && (state_nxt != state)) begin
      to_cnt <= '0;
    end else if (state_nxt[0]) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag. Only rst clears it.
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timed_out) begin
      err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register with registered output decodes. The decodes follow the
  // next state, so the outputs change on the same edge as state_o.
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      state     <= LS_RUN;
      hsclk_sel <= 1'b0;
      stall     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hsclk_sel <= sel_nxt;
      stall     <= stall_nxt;
    end
  end

  // Hold counter. It keeps the block on LS for a while after a slow access.
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state and hold-counter logic. force_ls outranks CPU requests, and a
  // timeout outranks everything in the switch states.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      LS_RUN: begin
        if (cyc_valid && fast_req && !force_ls && (hold_cnt == '0)) begin
          state_nxt = TO_HS;
        end else if (cyc_valid && !fast_req) begin
          hold_nxt = HOLD_LOAD;
        end else if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - CNT_W'(1);
        end
      end
      TO_HS: begin
        if (timed_out || force_ls) begin
          state_nxt = TO_LS;
        end else if (hs_s && !ls_s) begin
          state_nxt = HS_RUN;
        end
      end
      HS_RUN: begin
        if (force_ls || (cyc_valid && !fast_req)) begin
          state_nxt = TO_LS;
        end
      end
      TO_LS: begin
        if (timed_out || (ls_s && !hs_s)) begin
          state_nxt = LS_RUN;
          hold_nxt  = HOLD_LOAD;
        end
      end
      default: begin
        state_nxt = LS_RUN;
      end
    endcase
  end

  // Output decode of the next state: HS select in TO_HS/HS_RUN, and stall in
  // both switch states.
  always_comb begin
    sel_nxt   = (state_nxt == TO_HS) || (state_nxt == HS_RUN);
    stall_nxt = (state_nxt == TO_HS) || (state_nxt == TO_LS);
  end

  assign state_o = state;

endmodule

// File: tb/tb_clksel_fsm.sv
// Testbench for clksel_fsm. It drives directed scenarios and then random
// traffic with a behavioural clock-switch emulator. Expected outputs come from
// a reference model of the selection rules, and feedback latency is modelled
// as a delay line of sampled inputs.
module tb_clksel_fsm;

  localparam int SYNC  = 2;
  localparam int HOLD  = 8;
  localparam int CNT_W = 8;
  localparam int TMO   = 16;

  localparam int M_LS_RUN = 0;
  localparam int M_TO_HS  = 1;
  localparam int M_HS_RUN = 2;
  localparam int M_TO_LS  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cyc_valid = 1'b0;
  logic       fast_req = 1'b0;
  logic       force_ls = 1'b0;
  logic       hs_fb = 1'b0;
  logic       ls_fb = 1'b1;
  logic       hsclk_sel;
  logic       stall;
  logic [1:0] state_o;
  logic       timeout_err;

  // Clock and reset.
  always #5 clk = ~clk;

  clksel_fsm #(
    .SYNC_STAGES(SYNC),
    .LS_HOLD_CYCLES(HOLD),
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .hsclk_in(clk),
    .rst(rst),
    .cyc_valid(cyc_valid),
    .fast_req(fast_req),
    .force_ls(force_ls),
    .hsclk_selected_in(hs_fb),
    .lsclk_selected_in(ls_fb),
    .hsclk_sel(hsclk_sel),
    .stall(stall),
    .state_o(state_o),
    .timeout_err(timeout_err)
  );

  // Scoreboard storage. Each entry packs {timeout_err, stall, hsclk_sel, state_o}.
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_mode  = M_LS_RUN;
  int m_hold  = 0;
  int m_tcnt  = 0;
  bit m_err   = 1'b0;
  bit hs_hist[$];
  bit ls_hist[$];

  // Emulator state for the clock switch, used in the random phase.
  bit fb_hs = 1'b0;
  bit fb_ls = 1'b1;
  int fb_wait = 0;
  bit settled;
  bit m_sel;

  // Advance the model by one rising edge with the given inputs.
  task automatic model_step(input bit r, input bit c, input bit f, input bit fl,
                            input bit h, input bit l);
    bit hs_s;
    bit ls_s;
    bit tmo;
    int nxt;
    if (r) begin
      m_mode = M_LS_RUN;
      m_hold = 0;
      m_tcnt = 0;
      m_err  = 1'b0;
      hs_hist.delete();
      ls_hist.delete();
      for (int i = 0; i < SYNC; i++) begin
        hs_hist.push_back(1'b0);
        ls_hist.push_back(1'b1);
      end
    end else begin
      hs_s = hs_hist.pop_front();
      ls_s = ls_hist.pop_front();
      hs_hist.push_back(h);
      ls_hist.push_back(l);
      tmo = 1'b0;
`ifdef SWITCH_TIMEOUT_EN
      tmo = ((m_mode == M_TO_HS) || (m_mode == M_TO_LS)) && (m_tcnt == TMO);
`endif
      nxt = m_mode;
      if (m_mode == M_LS_RUN) begin
        if (c && f && !fl && m_hold == 0) nxt = M_TO_HS;
        else if (c && !f) m_hold = HOLD;
        else if (m_hold > 0) m_hold = m_hold - 1;
      end else if (m_mode == M_TO_HS) begin
        if (tmo) begin
          m_err = 1'b1;
          nxt = M_TO_LS;
        end else if (fl) nxt = M_TO_LS;
        else if (hs_s && !ls_s) nxt = M_HS_RUN;
      end else if (m_mode == M_HS_RUN) begin
        if (fl || (c && !f)) nxt = M_TO_LS;
      end else begin
        if (tmo) m_err = 1'b1;
        if (tmo || (ls_s && !hs_s)) begin
          nxt = M_LS_RUN;
          m_hold = HOLD;
        end
      end
      if (nxt == M_TO_HS || nxt == M_TO_LS) begin
        if (nxt != m_mode) m_tcnt = 0;
        else m_tcnt = m_tcnt + 1;
      end
      m_mode = nxt;
    end
  endtask

  function automatic logic [4:0] model_out();
    logic [1:0] code;
    code = m_mode[1:0];
    return {m_err, (m_mode == M_TO_HS || m_mode == M_TO_LS),
            (m_mode == M_TO_HS || m_mode == M_HS_RUN), code};
  endfunction

  // Driver: apply one cycle of inputs at the falling edge and queue the
  // expected outputs after the next rising edge.
  task automatic drive(input bit r, input bit c, input bit f, input bit fl,
                       input bit h, input bit l);
    @(negedge clk);
    rst       = r;
    cyc_valid = c;
    fast_req  = f;
    force_ls  = fl;
    hs_fb     = h;
    ls_fb     = l;
    model_step(r, c, f, fl, h, l);
    exp_q.push_back(model_out());
  endtask

  // Monitor: compare the DUT outputs shortly after each rising edge.
  initial begin
    logic [4:0] exp;
    logic [4:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {timeout_err, stall, hsclk_sel, state_o};
        n_checks++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL outputs @%0t: got state_o=%0d hsclk_sel=%0b stall=%0b timeout_err=%0b, expected state_o=%0d hsclk_sel=%0b stall=%0b timeout_err=%0b",
                   $time, act[1:0], act[2], act[3], act[4], exp[1:0], exp[2], exp[3], exp[4]);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bit r;
    bit c;
    bit f;
    bit fl;
    // Reset with feedback on LS.
    repeat (2) drive(1, 0, 0, 0, 0, 1);
    // LS -> HS: request, drop LS feedback, raise HS feedback 3 cycles later.
    drive(0, 1, 1, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 1, 0);
    // HS_RUN: a fast cycle stays, a slow cycle goes back to LS.
    drive(0, 1, 1, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    // Hold: fast request 3 cycles after LS_RUN entry is served on LS,
    // and the one 9 cycles after entry switches.
    repeat (2) drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 1);
    repeat (5) drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 1);
    // force_ls in TO_HS together with a fast request.
    drive(0, 1, 1, 1, 0, 1);
    repeat (3) drive(0, 0, 0, 1, 0, 1);
    repeat (12) drive(0, 1, 1, 1, 0, 1);
    // Stuck HS feedback.
    drive(0, 1, 1, 0, 0, 1);
    repeat (40) drive(0, 0, 0, 0, 0, 1);
    // Reset in the middle of a switch.
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);

    // Random traffic against a switch emulator that follows the select.
    fb_hs = 1'b0;
    fb_ls = 1'b1;
    fl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 2) == 0);
      f = $urandom_range(0, 1);
      if ($urandom_range(0, 39) == 0) fl = !fl;
      m_sel = (m_mode == M_TO_HS) || (m_mode == M_HS_RUN);
      settled = m_sel ? (fb_hs && !fb_ls) : (fb_ls && !fb_hs);
      if (!settled) begin
        if (fb_wait > 0) begin
          fb_wait--;
        end else begin
          if (m_sel && fb_ls) fb_ls = 1'b0;
          else if (!m_sel && fb_hs) fb_hs = 1'b0;
          else if (m_sel) fb_hs = 1'b1;
          else fb_ls = 1'b1;
          fb_wait = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 30)
                                                  : $urandom_range(0, 3);
        end
      end
      drive(r, c, f, fl, fb_hs, fb_ls);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
